// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle RV32I datapath (lw, sw, R/I ALU, beq, jal).
// Memory states wait on mem_ready under a watchdog; illegal encodings and timeouts trap until reset.
module multicycle_controller #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned WCNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       retire,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state_dbg
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                illegal_q, illegal_d;
    logic                timeout_q, timeout_d;

    logic                f3_alu_ok;
    logic                instr_legal;
    logic                mem_wait;
    logic                wd_expired;
    alu_op_t             alu_op;

    always_comb begin
        f3_alu_ok = funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
        case (op)
            OP_LW, OP_SW: instr_legal = (funct3 == 3'b010);
            OP_R:         instr_legal = f3_alu_ok && (!funct7b5 || funct3 == 3'b000);
            OP_I:         instr_legal = f3_alu_ok;
            OP_BEQ:       instr_legal = (funct3 == 3'b000);
            OP_JAL:       instr_legal = 1'b1;
            default:      instr_legal = 1'b0;
        endcase
    end

    // Only states stalled on memory count; mem_ready on the last allowed cycle still wins.
    assign mem_wait   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign wd_expired = mem_wait && !mem_ready && (wcnt_q == WCNT_LAST);

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!instr_legal) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXECR;
                        OP_I:         state_d = S_EXECI;
                        OP_JAL:       state_d = S_JAL;
                        default:      state_d = S_BEQ;
                    endcase
                end
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        if (wd_expired) begin
            state_d   = S_TRAP;
            timeout_d = 1'b1;
        end

        wcnt_d = wcnt_q;
        if (state_d != state_q) begin
            wcnt_d = '0;
        end else if (mem_wait && !mem_ready) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wcnt_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_SUB;
                pc_write  = zero;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALUOP_SUB: alu_control = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] && funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default:   alu_control = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction sequences, traps, watchdog edge and reset abort.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = OP_LW;
    logic [2:0] funct3 = 3'b010;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       retire, illegal, timeout;
    logic [3:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_controller #(.WAIT_LIMIT(16), .WCNT_W(5)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .retire(retire),
        .illegal(illegal), .timeout(timeout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] st;
        logic [2:0] alu;
    } alu_vec_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
    } enc_t;

    alu_vec_t alu_vecs [9];
    enc_t     bad_encs [7];
    int lw_st  [10] = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
    int lw_mr  [10] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int lw_ret [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic set_ir(input logic [6:0] o, input logic [2:0] f, input logic b);
        op = o;
        funct3 = f;
        funct7b5 = b;
    endtask

    // Runs FETCH (ready at once) and DECODE; returns at the start of the following state.
    task automatic fetch_decode();
        mem_ready = 1'b1;
        #1;
        check("fetch_state", 32'(state_dbg), 0);
        check("fetch_ir_write", 32'(ir_write), 1);
        step();
        mem_ready = 1'b0;
        #1;
        check("decode_state", 32'(state_dbg), 1);
        check("decode_src_ab", 32'({alu_src_a, alu_src_b}), 32'b0101);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout: time limit reached before completion");
        $fatal(1);
    end

    initial begin
        alu_vecs = '{
            '{OP_R, 3'b000, 1'b1, 4'd6, 3'b001},
            '{OP_R, 3'b000, 1'b0, 4'd6, 3'b000},
            '{OP_R, 3'b010, 1'b0, 4'd6, 3'b101},
            '{OP_R, 3'b110, 1'b0, 4'd6, 3'b011},
            '{OP_R, 3'b111, 1'b0, 4'd6, 3'b010},
            '{OP_I, 3'b000, 1'b1, 4'd8, 3'b000},
            '{OP_I, 3'b010, 1'b0, 4'd8, 3'b101},
            '{OP_I, 3'b110, 1'b0, 4'd8, 3'b011},
            '{OP_I, 3'b111, 1'b0, 4'd8, 3'b010}
        };
        bad_encs = '{
            '{OP_LUI, 3'b000, 1'b0},
            '{OP_R,   3'b001, 1'b0},
            '{OP_R,   3'b010, 1'b1},
            '{OP_LW,  3'b000, 1'b0},
            '{OP_BEQ, 3'b001, 1'b0},
            '{OP_SW,  3'b011, 1'b0},
            '{OP_I,   3'b100, 1'b0}
        };

        // Reset values
        do_reset();
        #1;
        check("rst_state", 32'(state_dbg), 0);
        check("rst_mem_read", 32'(mem_read), 1);
        check("rst_src", 32'({adr_src, alu_src_a, alu_src_b}), 32'b00010);
        check("rst_result_src", 32'(result_src), 2);
        check("rst_alu", 32'(alu_control), 0);
        check("rst_enables", 32'({ir_write, pc_write, reg_write, mem_write, retire}), 0);
        check("rst_flags", 32'({illegal, timeout}), 0);
        mem_ready = 1'b1;
        #1;
        check("rst_ready_writes", 32'({ir_write, pc_write}), 32'b11);
        mem_ready = 1'b0;

        // lw with two stall cycles in FETCH and MEMREAD
        do_reset();
        set_ir(OP_LW, 3'b010, 1'b0);
        for (int i = 0; i < 10; i++) begin
            mem_ready = lw_mr[i][0];
            #1;
            check($sformatf("lw_state%0d", i), 32'(state_dbg), lw_st[i]);
            check($sformatf("lw_retire%0d", i), 32'(retire), lw_ret[i]);
            check($sformatf("lw_reg_write%0d", i), 32'(reg_write), lw_ret[i]);
            if (lw_st[i] == 3) check("lw_memread_adr", 32'({adr_src, mem_read}), 32'b11);
            if (lw_st[i] == 4) check("lw_memwb_result", 32'(result_src), 1);
            step();
        end

        // R-type and I-type ALU instructions, back to back
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_ir(alu_vecs[i].op, alu_vecs[i].f3, alu_vecs[i].f7);
            fetch_decode();
            #1;
            check($sformatf("alu%0d_state", i), 32'(state_dbg), 32'(alu_vecs[i].st));
            check($sformatf("alu%0d_control", i), 32'(alu_control), 32'(alu_vecs[i].alu));
            check($sformatf("alu%0d_src_b", i), 32'(alu_src_b), (alu_vecs[i].st == 4'd6) ? 0 : 1);
            check($sformatf("alu%0d_src_a", i), 32'(alu_src_a), 2);
            step();
            #1;
            check($sformatf("alu%0d_wb_state", i), 32'(state_dbg), 7);
            check($sformatf("alu%0d_wb", i), 32'({reg_write, retire, result_src}), 32'b1100);
            step();
        end

        // beq taken and not taken
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_ir(OP_BEQ, 3'b000, 1'b0);
            zero = (i == 0);
            fetch_decode();
            #1;
            check($sformatf("beq%0d_state", i), 32'(state_dbg), 10);
            check($sformatf("beq%0d_pc_write", i), 32'(pc_write), (i == 0) ? 1 : 0);
            check($sformatf("beq%0d_retire", i), 32'(retire), 1);
            check($sformatf("beq%0d_alu", i), 32'(alu_control), 1);
            check($sformatf("beq%0d_imm", i), 32'(imm_src), 2);
            step();
            #1;
            check($sformatf("beq%0d_back", i), 32'(state_dbg), 0);
        end
        zero = 1'b0;

        // jal
        set_ir(OP_JAL, 3'b000, 1'b0);
        fetch_decode();
        #1;
        check("jal_state", 32'(state_dbg), 9);
        check("jal_ctrl", 32'({pc_write, alu_src_a, alu_src_b, reg_write, retire}), 32'b1011000);
        check("jal_imm", 32'(imm_src), 3);
        step();
        #1;
        check("jal_wb_state", 32'(state_dbg), 7);
        check("jal_wb", 32'({reg_write, retire, pc_write}), 32'b110);
        step();

        // Illegal encodings trap; first one also holds through mem_ready and clears on reset
        for (int i = 0; i < 7; i++) begin
            do_reset();
            set_ir(bad_encs[i].op, bad_encs[i].f3, bad_encs[i].f7);
            fetch_decode();
            #1;
            check($sformatf("bad%0d_state", i), 32'(state_dbg), 11);
            check($sformatf("bad%0d_flags", i), 32'({illegal, timeout}), 32'b10);
            if (i == 0) begin
                mem_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    step();
                    #1;
                    check("trap_hold_state", 32'(state_dbg), 11);
                    check("trap_hold_out", 32'({illegal, ir_write, pc_write, mem_read, retire}), 32'b10000);
                end
                do_reset();
                #1;
                check("trap_rst_clear", 32'({state_dbg, illegal, timeout}), 0);
            end
        end

        // Watchdog in MEMWRITE: 16 stalled cycles then trap
        do_reset();
        set_ir(OP_SW, 3'b010, 1'b0);
        fetch_decode();
        #1;
        check("sw_memadr", 32'({state_dbg, alu_src_a, alu_src_b, imm_src}), 32'b0010_10_01_01);
        step();
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("sw_wait%0d", i), 32'({state_dbg, mem_write, adr_src, retire}), 32'b0101_110);
            step();
        end
        #1;
        check("sw_to_state", 32'(state_dbg), 11);
        check("sw_to_flags", 32'({illegal, timeout}), 32'b01);
        check("sw_to_mem_write", 32'(mem_write), 0);
        step();
        #1;
        check("sw_to_sticky", 32'({state_dbg, timeout}), 32'b1011_1);

        // mem_ready on the final allowed cycle completes normally
        do_reset();
        set_ir(OP_SW, 3'b010, 1'b0);
        fetch_decode();
        step();
        for (int i = 0; i < 15; i++) step();
        mem_ready = 1'b1;
        #1;
        check("sw_edge_state", 32'(state_dbg), 5);
        check("sw_edge_retire", 32'(retire), 1);
        step();
        mem_ready = 1'b0;
        #1;
        check("sw_edge_next", 32'({state_dbg, timeout}), 0);

        // Watchdog in FETCH
        do_reset();
        for (int i = 0; i < 16; i++) step();
        #1;
        check("fetch_to", 32'({state_dbg, timeout, mem_read}), 32'b1011_1_0);

        // Reset during MEMREAD aborts the load
        do_reset();
        set_ir(OP_LW, 3'b010, 1'b0);
        fetch_decode();
        step();
        #1;
        check("abort_memread", 32'(state_dbg), 3);
        mem_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("abort_state", 32'(state_dbg), 0);
        check("abort_out", 32'({reg_write, retire, illegal, timeout}), 0);
        step();
        #1;
        check("abort_stays_fetch", 32'({state_dbg, reg_write, retire}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
